// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the button event controller:
//   - btn_state_e : event FSM states (IDLE / PRESSED / LONG_HELD)
//   - LED_ON_*    : active-high {r,g,b} colour per mode (1 = colour lit)
//   - led_on      : mode -> active-high {r,g,b} lookup
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_e;

  // Colour table, {r,g,b}, 1 = colour lit. Pins are active-low, so the top
  // inverts these on the way out.
  localparam logic [2:0] LED_ON_M0 = 3'b100;  // R
  localparam logic [2:0] LED_ON_M1 = 3'b010;  // G
  localparam logic [2:0] LED_ON_M2 = 3'b001;  // B
  localparam logic [2:0] LED_ON_M3 = 3'b111;  // RGB
  localparam logic [2:0] LED_ON_M4 = 3'b110;  // RG
  localparam logic [2:0] LED_ON_M5 = 3'b011;  // GB
  localparam logic [2:0] LED_ON_M6 = 3'b101;  // RB
  localparam logic [2:0] LED_ON_M7 = 3'b000;  // none

  function automatic logic [2:0] led_on(input logic [2:0] m);
    logic [2:0] c;
    case (m)
      3'd0:    c = LED_ON_M0;
      3'd1:    c = LED_ON_M1;
      3'd2:    c = LED_ON_M2;
      3'd3:    c = LED_ON_M3;
      3'd4:    c = LED_ON_M4;
      3'd5:    c = LED_ON_M5;
      3'd6:    c = LED_ON_M6;
      default: c = LED_ON_M7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/button_event_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// debounce_filter
//   Counter-based debounce. The accepted level only changes once the raw
//   input has disagreed with it for DB_CYCLES consecutive clock edges; any
//   shorter disagreement restarts the count.
// Ports
//   pin_clk_12mhz  in  system clock
//   rst_n          in  synchronous reset, active low
//   raw            in  raw button level, 1 = pressed
//   level          out debounced level, 1 = pressed
// ---------------------------------------------------------------------------
module debounce_filter
  import button_pkg::*;
#(
  parameter int DB_CYCLES = 120_000
) (
  input  logic pin_clk_12mhz,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  always_ff @(posedge pin_clk_12mhz) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (raw == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      // This edge is the DB_CYCLES-th consecutive disagreeing sample.
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign level = r_level;

endmodule

// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
//   Turns the synchronised active-low user button into clean events:
//   debounced level, one-cycle press/release/long-press pulses, a mode
//   register (short press = next mode, long press = mode 0) and the RGB LED
//   drive showing the current mode.
// Ports
//   pin_clk_12mhz  in   system clock
//   rst_n          in   synchronous reset, active low
//   sw_sync_n      in   synchronised button, 0 = pressed
//   btn_level      out  debounced level, 1 = pressed
//   press_pulse    out  1-cycle pulse on accepted press
//   release_pulse  out  1-cycle pulse on accepted release
//   long_pulse     out  1-cycle pulse when the hold reaches LONG_CYCLES
//   mode           out  current mode, 0..NUM_MODES-1
//   led_r_n/g_n/b_n out RGB LED drives, 0 = LED on
// ---------------------------------------------------------------------------
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int DB_CYCLES   = 120_000,
  parameter int LONG_CYCLES = 12_000_000,
  parameter int NUM_MODES   = 4,
  parameter int MODE_W      = $clog2(NUM_MODES)
) (
  input  logic              pin_clk_12mhz,
  input  logic              rst_n,
  input  logic              sw_sync_n,
  output logic              btn_level,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              long_pulse,
  output logic [MODE_W-1:0] mode,
  output logic              led_r_n,
  output logic              led_g_n,
  output logic              led_b_n
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  logic              w_level;
  btn_state_e        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic [MODE_W-1:0] r_mode;
  logic [2:0]        r_led_n;

  debounce_filter #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .pin_clk_12mhz (pin_clk_12mhz),
    .rst_n         (rst_n),
    .raw           (~sw_sync_n),
    .level         (w_level)
  );

  // Event FSM: reacts to the debounced level one cycle after it changes, so
  // every pulse lags its btn_level edge by exactly one clock.
  always_ff @(posedge pin_clk_12mhz) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_mode     <= '0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_level) begin
            r_press    <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // Release is checked first so a release landing on the long
          // threshold still counts as a short press.
          if (!w_level) begin
            r_release <= 1'b1;
            r_mode    <= (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_long  <= 1'b1;
            r_state <= ST_LONG_HELD;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!w_level) begin
            r_release <= 1'b1;
            r_mode    <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // LED drive follows the mode register one cycle later.
  always_ff @(posedge pin_clk_12mhz) begin
    if (!rst_n) begin
      r_led_n <= ~LED_ON_M0;
    end else begin
      r_led_n <= ~led_on(3'(r_mode));
    end
  end

  assign btn_level     = w_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign mode          = r_mode;
  assign led_r_n       = r_led_n[2];
  assign led_g_n       = r_led_n[1];
  assign led_b_n       = r_led_n[0];

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int NM   = 4;
  localparam int MW   = 2;
  localparam int MAXC = 65536;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw;
  logic          btn_level, press_pulse, release_pulse, long_pulse;
  logic [MW-1:0] mode;
  logic          led_r_n, led_g_n, led_b_n;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG),
    .NUM_MODES   (NM)
  ) dut (
    .pin_clk_12mhz (clk),
    .rst_n         (rst_n),
    .sw_sync_n     (sw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .mode          (mode),
    .led_r_n       (led_r_n),
    .led_g_n       (led_g_n),
    .led_b_n       (led_b_n)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp, input int c);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, exp);
    end
  endtask

  // LED pins {r,g,b}_n expected for a mode, written straight from the colour list.
  function automatic logic [2:0] led_for(input int m);
    case (m)
      0: return 3'b011;  // R
      1: return 3'b101;  // G
      2: return 3'b110;  // B
      3: return 3'b000;  // RGB
      4: return 3'b001;  // RG
      5: return 3'b100;  // GB
      6: return 3'b010;  // RB
      default: return 3'b111;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Event kinds: {press, release, long}
  typedef struct {
    int         cyc;
    logic [2:0] kind;
    int         mode;
  } ev_t;
  ev_t q[$];

  int         cyc = 0;
  int         rst_edge = 0;
  bit         mvalid = 0;
  logic       raw_hist [0:MAXC-1];
  logic       mlevel, prev_level;
  bit         held, longd, all_diff;
  int         pedge, mmode;
  logic [2:0] led_exp;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mvalid  = 1;
      mlevel  = 1'b0;
      held    = 0;
      longd   = 0;
      mmode   = 0;
      led_exp = led_for(0);
      rst_edge = cyc;
      q.delete();
    end else begin
      prev_level = mlevel;
      raw_hist[cyc] = ~sw;
      // Level flips once the last DB samples since reset all disagree with it.
      if (cyc - rst_edge >= DB) begin
        all_diff = 1;
        for (int k = 0; k < DB; k++)
          if (raw_hist[cyc-k] == mlevel) all_diff = 0;
        if (all_diff) mlevel = ~mlevel;
      end
      led_exp = led_for(mmode);
      if (!held && prev_level) begin
        q.push_back('{cyc, 3'b100, mmode});
        held = 1; longd = 0; pedge = cyc;
      end else if (held && !prev_level) begin
        mmode = longd ? 0 : (mmode + 1) % NM;
        q.push_back('{cyc, 3'b010, mmode});
        held = 0;
      end else if (held && !longd && cyc == pedge + LONG) begin
        q.push_back('{cyc, 3'b001, mmode});
        longd = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] act;
  ev_t        e;

  always @(negedge clk) begin
    if (mvalid) begin
      act = {press_pulse, release_pulse, long_pulse};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_pulse", 0, int'(e.kind), e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("pulse", int'(act), int'(e.kind), cyc);
        if (e.kind[1]) chk("mode_after_release", int'(mode), e.mode, cyc);
      end else if (act != 3'b000) begin
        chk("unexpected_pulse", int'(act), 0, cyc);
      end
      chk("btn_level", int'(btn_level), int'(mlevel), cyc);
      chk("mode", int'(mode), mmode, cyc);
      chk("led", int'({led_r_n, led_g_n, led_b_n}), int'(led_exp), cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit pressed, input int n);
    sw = ~pressed;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 5);
    // glitch shorter than the debounce window
    drive(1, 3);
    drive(0, 10);
    // single short press
    drive(1, 10);
    drive(0, 10);
    // four short presses walk the modes round
    for (int i = 0; i < 4; i++) begin
      drive(1, 8);
      drive(0, 8);
    end
    // long hold
    drive(1, 40);
    drive(0, 10);
    // release landing exactly on the long threshold, then one cycle later
    drive(1, 20);
    drive(0, 10);
    drive(1, 21);
    drive(0, 10);
    // reset while pressed, button kept held
    drive(1, 12);
    pulse_reset();
    drive(1, 12);
    drive(0, 10);
    // randomized presses, glitches and occasional resets
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset();
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 30));
    end
    drive(0, 40);
    chk("queue_drained", q.size(), 0, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
